// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, shifts stepped one bit per cycle.
// Valid/ready request in, valid/ready result out; one operation in flight.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, illegal_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             alu_shift;
  logic [WIDTH-1:0] shift_one;

  // Single-cycle evaluation of the request on the input pins; a shift by
  // zero collapses to a pass-through of a.
  always_comb begin
    alu_res   = '0;
    alu_ill   = 1'b0;
    alu_shift = 1'b0;
    case (ALUControl)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res   = a;
        alu_shift = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_one = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, work_q[WIDTH-1:1]};
      default: shift_one = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result;
    zero_d    = zero;
    illegal_d = illegal;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALUControl;
          if (alu_shift && (b[4:0] != 5'd0)) begin
            work_d  = a;
            cnt_d   = b[4:0];
            state_d = SHIFT;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shift_one;
        cnt_d  = cnt_q - 5'd1;
        // The last step lands directly in the result register so the
        // result is visible N+1 cycles after accept.
        if (cnt_q == 5'd1) begin
          result_d  = shift_one;
          zero_d    = (shift_one == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      result  <= result_d;
      zero    <= zero_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases then randomized ops against a
// plain-arithmetic reference model (result, flags, latency, handshake).
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'b0000: return x + y;
      4'b1000: return x - y;
      4'b0001: return x << y[4:0];
      4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0011: return (x < y) ? 32'd1 : 32'd0;
      4'b0100: return x ^ y;
      4'b0101: return x >> y[4:0];
      4'b1101: return 32'($signed(x) >>> y[4:0]);
      4'b0110: return x | y;
      4'b0111: return x & y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [3:0] op);
    return !(op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                        4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111});
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
    if ((op inside {4'b0001, 4'b0101, 4'b1101}) && (y[4:0] != 5'd0))
      return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // One full transaction: accept, wait for result, optional stall, consume.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input int stall);
    logic [31:0] er;
    int          el, lat;
    er = ref_res(op, av, bv);
    el = ref_lat(op, bv);
    @(negedge clk);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; ALUControl = op; a = av; b = bv;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    // Scramble inputs after accept; none of it may reach the result.
    in_valid = 1'($urandom_range(0, 1)); ALUControl = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'd0));
    chk("illegal", 32'(illegal), 32'(ref_ill(op)));
    chk("busy_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", result, er);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    // in_valid stays high across the consume edge: must not be accepted.
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] codes [12];
    int         seen;
    codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
              4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001, 4'b1111};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 4'd0; a = 32'd0; b = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
    reset = 1'b0;

    run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b1101, 32'h8000_0000, 32'd4, 0);
    chk("sra_vec", ref_res(4'b1101, 32'h8000_0000, 32'd4), 32'hF800_0000);
    run_op(4'b0101, 32'h8000_0000, 32'd4, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(4'b1000, 32'd5, 32'd7, 10);
    run_op(4'b0001, 32'h0000_0001, 32'd31, 1);
    run_op(4'b1101, 32'hDEAD_BEEF, 32'h0000_0020, 0);
    run_op(4'b0001, 32'h8000_0001, 32'd1, 2);

    for (int n = 0; n < 40; n++)
      run_op(codes[$urandom_range(0, 11)], $urandom, $urandom, int'($urandom_range(0, 3)));

    // Reset in the middle of a long shift discards the operation.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'b0001; a = 32'd1; b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pre_abort_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {30'd0, zero, illegal}, 32'd0);
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_never_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;

    run_op(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and result; shift amount taken from b[4:0].
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operation request valid.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 ALUControl  in  4  operation code, sampled on accept.
REQ-008 a  in  WIDTH  operand A, sampled on accept.
REQ-009 b  in  WIDTH  operand B, sampled on accept.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 result  out  WIDTH  operation result.
REQ-013 zero  out  1  result equals 0.
REQ-014 illegal  out  1  accepted ALUControl was not a defined code.

Function
REQ-015 Codes: 0000 add; 1000 sub (a-b); 0001 sll; 0010 slt (signed, result 1/0); 0011 sltu (unsigned); 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and.
REQ-016 Any other code: result 0, zero 1, illegal 1, single-cycle path; illegal is 0 for all defined codes.
REQ-017 Arithmetic modulo 2^WIDTH; carry/overflow discarded.
REQ-018 FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-019 Accept = in_valid & in_ready on a rising edge; operands and code captured into internal registers; later input changes have no effect.
REQ-020 IDLE, accept, non-shift op: result registered, next state DONE; out_valid asserts the cycle after accept (latency 1).
REQ-021 IDLE, accept, shift op with b[4:0]=0: result = a, next state DONE (latency 1).
REQ-022 IDLE, accept, shift op with b[4:0]=N>0: working reg = a, counter = N, next state SHIFT.
REQ-023 SHIFT: each cycle shift working reg by exactly one bit (sll fill 0; srl fill 0; sra fill with bit WIDTH-1), decrement counter; on counter reaching 0 go to DONE; out_valid asserts N+1 cycles after accept.
REQ-024 DONE: out_valid 1; result, zero, illegal stable; stay until out_ready; on out_valid & out_ready go to IDLE.
REQ-025 No new request accepted in the cycle the result is consumed (in_ready low in DONE); next accept earliest the following cycle.
REQ-026 in_valid without in_ready ignored; out_ready while out_valid low ignored.
REQ-027 zero and illegal registered with result; update only on entering DONE.
REQ-028 result held at last value in IDLE and SHIFT (out_valid low there).

Reset
REQ-029 reset high: state IDLE, out_valid 0, result 0, zero 0, illegal 0, counter 0, in_ready 1 the following cycle.
REQ-030 reset in SHIFT or DONE aborts the operation; pending result discarded, never presented.
REQ-031 reset has priority over accept and over out_ready in the same cycle.

Verification
REQ-032 ALUControl=0000, a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, result 0x00000000, zero 1, illegal 0.
REQ-033 ALUControl=1101, a=0x80000000, b=4 -> out_valid 5 cycles after accept, result 0xF8000000; ALUControl=0101 same operands -> 0x08000000.
REQ-034 ALUControl=0010, a=0xFFFFFFFF, b=1 -> result 1; ALUControl=0011 same operands -> result 0, zero 1.
REQ-035 out_ready held 0 for 10 cycles after result -> out_valid, result stable, in_ready 0 throughout; in_valid pulses ignored; out_ready 1 -> IDLE next cycle.
REQ-036 ALUControl=1111 -> result 0, zero 1, illegal 1, latency 1.
REQ-037 sll a=1, b=31, reset asserted 3 cycles after accept -> out_valid never asserts, outputs 0, in_ready 1 the cycle after reset deasserts.
